// File: rtl/mul_seq_16_if.sv
// ---------------------------------------------------------------------------
// mul_seq_16_if
//   Request/result bundle for the sequential multiplier mul_seq_16.
//
//   Signals:
//     start  request a multiply (requester -> multiplier)
//     a, b   operands, sampled on the accepting edge (requester -> multiplier)
//     busy   high while an operation is iterating (multiplier -> requester)
//     done   one-cycle pulse when the result is valid (multiplier -> requester)
//     ld     copy of done, load enable for the downstream register
//     out    low WIDTH bits of the product, held until the next result
//     ovf    product did not fit in WIDTH bits, held alongside out
//
//   Handshake: start is a request that is only accepted when the multiplier
//   is not busy (IDLE or DONE). There is no ready signal: a requester that
//   keeps start high while busy is simply ignored until the block frees up.
//   done/ld is a single-cycle strobe with no back-pressure; the consumer must
//   capture out on the edge where it samples ld=1.
//
//   Modports: master = requester/consumer side, slave = multiplier side.
// ---------------------------------------------------------------------------
interface mul_seq_16_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             ld;
    logic [WIDTH-1:0] out;
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, ld, out, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, ld, out, ovf
    );
endinterface

// File: rtl/mul_seq_16.sv
// ---------------------------------------------------------------------------
// mul_seq_16
//   Sequential shift-and-add multiplier. One operand bit is consumed per
//   clock, so a product takes WIDTH cycles in RUN followed by one DONE cycle
//   in which done/ld pulse. The result (out, ovf) is registered and held
//   until the next result or a reset.
//
//   Ports:
//     clk        rising-edge clock
//     reset      asynchronous, active-low reset
//     bus        mul_seq_16_if.slave: start/a/b in, busy/done/ld/out/ovf out
//     state_dbg  current FSM state (IDLE=0, RUN=1, DONE=2) for observation
//
//   Build option:
//     MUL_SIGNED_EN  when defined, a and b are two's-complement. Magnitudes
//                    are multiplied and the product is negated at the result
//                    edge when the operand signs differ. Overflow then means
//                    the signed product is outside the signed WIDTH range.
// ---------------------------------------------------------------------------
module mul_seq_16 #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    mul_seq_16_if.slave bus,
    output logic [1:0]  state_dbg
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   out_q;
    logic               ovf_q;

    logic               accept;
    logic               last_iter;
    logic               busy_c;
    logic               done_c;

    logic [2*WIDTH-1:0] acc_sum;
    logic [2*WIDTH-1:0] result;
    logic               ovf_c;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;

`ifdef MUL_SIGNED_EN
    logic               sign_q;
    logic               sign_in;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        last_iter = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    last_iter = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                done_c = 1'b1;
                // A request in DONE is taken immediately for back-to-back use.
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand conditioning and result formation
    // ------------------------------------------------------------------
    // mcand is 2*WIDTH wide so the running sum never loses a carry.
    assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

`ifdef MUL_SIGNED_EN
    // Negating the most negative value yields itself, which is also its
    // correct unsigned magnitude, so no special case is needed.
    assign op_a    = bus.a[WIDTH-1] ? (-bus.a) : bus.a;
    assign op_b    = bus.b[WIDTH-1] ? (-bus.b) : bus.b;
    assign sign_in = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
    assign result  = sign_q ? (-acc_sum) : acc_sum;
    // The signed product fits in WIDTH bits only if bits [2W-1:W-1] are
    // a pure sign extension (all zeros or all ones).
    assign ovf_c   = !((&result[2*WIDTH-1:WIDTH-1]) || (~|result[2*WIDTH-1:WIDTH-1]));
`else
    assign op_a    = bus.a;
    assign op_b    = bus.b;
    assign result  = acc_sum;
    assign ovf_c   = |result[2*WIDTH-1:WIDTH];
`endif

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
`ifdef MUL_SIGNED_EN
            sign_q   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                mcand_q  <= {{WIDTH{1'b0}}, op_a};
                mplier_q <= op_b;
                acc_q    <= '0;
                cnt_q    <= '0;
`ifdef MUL_SIGNED_EN
                sign_q   <= sign_in;
`endif
            end else if (state_q == RUN) begin
                acc_q    <= acc_sum;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + 1'b1;
                if (last_iter) begin
                    out_q <= result[WIDTH-1:0];
                    ovf_q <= ovf_c;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from registers only
    // ------------------------------------------------------------------
    assign bus.busy  = busy_c;
    assign bus.done  = done_c;
    assign bus.ld    = done_c;
    assign bus.out   = out_q;
    assign bus.ovf   = ovf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mul_seq_16.sv
// ---------------------------------------------------------------------------
// tb_mul_seq_16
//   Directed bench for mul_seq_16 (WIDTH=16). A reference model computes the
//   product with plain integer arithmetic and predicts when each result
//   appears; a compare process checks every cycle against it, and the
//   directed sequences pin the model with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_mul_seq_16;

    localparam int W = 16;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       reset;
    logic [1:0] state_dbg;
    int         cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mul_seq_16_if #(.WIDTH(W)) bus ();

    mul_seq_16 #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Downstream load-enabled register fed by out/ld.
    logic [W-1:0] ds_q;
    always @(posedge clk or negedge reset) begin
        if (!reset) ds_q <= '0;
        else if (bus.ld) ds_q <= bus.out;
    end

    // ---------------- bookkeeping ----------------
    int checks;
    int errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                    output logic [W-1:0] o, output logic v);
        longint p;
`ifdef MUL_SIGNED_EN
        shortint sx;
        shortint sy;
        sx = x;
        sy = y;
        p  = longint'(sx) * longint'(sy);
        v  = (p < -32768) || (p > 32767);
`else
        p  = longint'(x) * longint'(y);
        v  = (p > 65535);
`endif
        o = p[W-1:0];
    endfunction

    logic [W-1:0] exp_q[$];
    int           m_rem;     // cycles of RUN still to go; 0 when free
    logic         m_done;
    logic [W-1:0] m_out;
    logic         m_ovf;
    logic [W-1:0] m_pend;
    logic         m_pend_ovf;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_rem  = 0;
            m_done = 1'b0;
            m_out  = '0;
            m_ovf  = 1'b0;
            exp_q.delete();
        end else begin
            automatic bit fin = (m_rem == 1);
            automatic bit acc = bus.start && (m_rem == 0);
            if (m_rem > 0) m_rem--;
            m_done = fin;
            if (fin) begin
                m_out = m_pend;
                m_ovf = m_pend_ovf;
            end
            if (acc) begin
                ref_mul(bus.a, bus.b, m_pend, m_pend_ovf);
                exp_q.push_back(m_pend);
                m_rem = W;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        check("cycle_outputs",
              {11'b0, bus.busy, bus.done, bus.ld, bus.ovf, bus.out},
              {11'b0, (m_rem > 0) ? 1'b1 : 1'b0, m_done, m_done, m_ovf, m_out});
        if (bus.done && reset) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_nonempty", 32'd0, 32'd1);
            end else begin
                check("scoreboard_out", {16'b0, bus.out}, {16'b0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom_range(0, 16'hFFFF));
        bus.b     = W'($urandom_range(0, 16'hFFFF));
    endtask

    task automatic wait_done(output int busy_cycles);
        bit ok;
        busy_cycles = 0;
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
            if (bus.busy) busy_cycles++;
        end
        check("done_seen", {31'b0, ok}, 32'd1);
    endtask

    task automatic run_vec(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] eo, input logic ev);
        int bc;
        start_op(x, y);
        wait_done(bc);
        check({name, "_busy_cycles"}, bc, W);
        check({name, "_out"}, {16'b0, bus.out}, {16'b0, eo});
        check({name, "_ovf"}, {31'b0, bus.ovf}, {31'b0, ev});
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] o;
        logic         v;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int bc;
        int t_first;
        int done_cnt;

        checks    = 0;
        errors    = 0;
        cyc       = 0;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

`ifdef MUL_SIGNED_EN
        vecs.push_back('{16'hFFFF, 16'hFFFF, 16'h0001, 1'b0});
        vecs.push_back('{16'h0100, 16'h00FF, 16'hFF00, 1'b1});
        vecs.push_back('{16'hFFFD, 16'h0005, 16'hFFF1, 1'b0});
        vecs.push_back('{16'h8000, 16'hFFFF, 16'h8000, 1'b1});
        vecs.push_back('{16'h8000, 16'h0001, 16'h8000, 1'b0});
`else
        vecs.push_back('{16'hFFFF, 16'hFFFF, 16'h0001, 1'b1});
        vecs.push_back('{16'h0100, 16'h00FF, 16'hFF00, 1'b0});
        vecs.push_back('{16'h8000, 16'h0002, 16'h0000, 1'b1});
        vecs.push_back('{16'h00FF, 16'h0101, 16'hFFFF, 1'b0});
`endif

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {11'b0, bus.busy, bus.done, bus.ld, bus.ovf, bus.out}, 32'd0);
        check("reset_state", {30'b0, state_dbg}, 32'd0);
        reset = 1'b1;

        // 3 x 5 and downstream capture one edge after done
        run_vec("mul_3x5", 16'd3, 16'd5, 16'h000F, 1'b0);
        check("ld_with_done", {31'b0, bus.ld}, 32'd1);
        @(posedge clk); #1;
        check("downstream_3x5", {16'b0, ds_q}, 32'h0000_000F);

        // Table of boundary vectors
        foreach (vecs[i]) begin
            run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].o, vecs[i].v);
        end

        // Zero operand still takes the full iteration count
        run_vec("mul_zero", 16'h0000, 16'h1234, 16'h0000, 1'b0);

        // start pulses with new operands during RUN are ignored
        start_op(16'h0123, 16'h0021);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.start = 1'b1;
            bus.a     = W'($urandom_range(1, 16'hFFFF));
            bus.b     = W'($urandom_range(1, 16'hFFFF));
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        wait_done(bc);
        check("ignore_start_busy", bc, W - 8);
        check("ignore_start_out", {16'b0, bus.out}, 32'h0000_2583);

        // Asynchronous reset part-way through RUN
        start_op(16'h0055, 16'h0066);
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", {11'b0, bus.busy, bus.done, bus.ld, bus.ovf, bus.out}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("no_done_after_reset", done_cnt, 0);
        run_vec("mul_2x2", 16'd2, 16'd2, 16'h0004, 1'b0);

        // Back-to-back with start held high
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a     = 16'd4;
        bus.b     = 16'd4;
        wait_done(bc);
        t_first = cyc;
        check("b2b_first_out", {16'b0, bus.out}, 32'h0000_0010);
        bus.a = 16'd6;
        bus.b = 16'd7;
        wait_done(bc);
        bus.start = 1'b0;
        check("b2b_spacing", cyc - t_first, W + 1);
        check("b2b_second_out", {16'b0, bus.out}, 32'h0000_002A);
        @(posedge clk); #1;
        check("downstream_b2b", {16'b0, ds_q}, 32'h0000_002A);

        // Result hold while idle
        repeat (5) @(posedge clk);
        #1;
        check("result_hold", {16'b0, bus.out}, 32'h0000_002A);
        check("scoreboard_drained", exp_q.size(), 0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mul_seq_16.md
# mul_seq_16

Sequential shift-and-add multiplier that computes the product of two WIDTH-bit operands over WIDTH clock cycles. It produces a registered WIDTH-bit result and a one-cycle load strobe. It sits directly upstream of the 16-bit load-enabled register stage: `out` drives that register's data input and `ld` drives its load enable, so the register captures exactly one result per multiply. An overflow flag reports products that do not fit in WIDTH bits.

## Interface
Parameters:
- WIDTH, 16, operand and result width; must be ≥ 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a multiply; sampled only in IDLE or DONE.
- a  input  WIDTH  multiplicand; sampled on the accepting edge.
- b  input  WIDTH  multiplier; sampled on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse in DONE.
- ld  output  1  identical to done; load strobe for the downstream register.
- out  output  WIDTH  low WIDTH bits of the product; registered.
- ovf  output  1  product exceeds the WIDTH-bit range; registered alongside out.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: if start=1, the block accepts the request:
  - mcand ← a, zero-extended to 2·WIDTH;
  - mplier ← b;
  - acc ← 0;
  - cnt ← 0;
  - next state RUN.
- IDLE with start=0: the state is held.
- RUN: each cycle, if mplier[0]=1 then acc ← acc + mcand, using a 2·WIDTH-bit add with no carry-out lost. Then mcand ← mcand << 1, mplier ← mplier >> 1, cnt ← cnt + 1.
- RUN exit: when cnt = WIDTH−1 the final iteration executes and the next state is DONE. In the same edge:
  - out ← low WIDTH bits of the final acc;
  - ovf ← (high WIDTH bits of the final acc ≠ 0).
- RUN and start: start is ignored. a and b may change freely without effect.
- DONE: lasts exactly one cycle, with done=ld=1.
  - If start=1 in DONE, the new request is accepted as from IDLE and the next state is RUN, giving back-to-back operation.
  - Otherwise the next state is IDLE.
- Result hold: out and ovf hold their value until the next DONE entry or a reset.
- Zero operands: a=0 or b=0 still takes the full WIDTH cycles and yields out=0, ovf=0.
- Reset: reset=0 at any time, including mid-RUN, forces IDLE immediately and asynchronously. The following are all cleared to 0 and the in-flight operation is discarded:
  - busy, done, ld, out, ovf;
  - acc, cnt, mcand, mplier.
- Reset release: the first start is honoured on the first rising edge after reset returns high.

## Timing
- Reset values: busy=0, done=0, ld=0, out=0, ovf=0, state=IDLE.
- Accepting edge E0: the state is RUN after E0, and busy=1 for WIDTH cycles (E0..E0+WIDTH−1).
- Result edge E0+WIDTH: out and ovf are updated, done=ld=1 for one cycle, and busy=0.
- Downstream capture: the register captures out on edge E0+WIDTH+1, when ld=1 is sampled.
- Latency: WIDTH+1 edges from accepting start to the result being visible in the downstream register.
- Throughput: one result per WIDTH+1 cycles, with start held high continuously.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- MUL_SIGNED_EN defined: a and b are two's-complement.
  - On accept, the magnitudes |a| and |b| are latched, and sign = a[MSB] ^ b[MSB] is stored.
  - At the result edge, acc is negated if sign=1.
  - out is the low WIDTH bits of the signed product.
  - ovf=1 when the signed product lies outside [−2^(WIDTH−1), 2^(WIDTH−1)−1]. For example, −2^(WIDTH−1)·1 gives ovf=0, and −2^(WIDTH−1)·−1 gives ovf=1.
  - Latency is unchanged.
- MUL_SIGNED_EN not defined: operands are unsigned, and overflow is as defined in Operation.

## Test plan
- Reset low, then release; start=1 with a=3, b=5 → busy high for 16 cycles, then done=ld=1 for one cycle with out=0x000F, ovf=0; the downstream register reads 0x000F one edge later.
- a=0xFFFF, b=0xFFFF unsigned → out=0x0001, ovf=1. Then a=0x0100, b=0x00FF → out=0xFF00, ovf=0.
- Start pulsed, with a and b changed, at several points during RUN → no restart, busy continuous, result equals the original operands' product.
- Reset asserted at cycle 7 of RUN → all outputs 0 immediately; no done pulse follows. A new start=1 of 2×2 after release → out=0x0004.
- start held high with two operand pairs (4×4, then 6×7 presented in the DONE cycle) → done pulses exactly 17 cycles apart; out=0x0010, then 0x002A.
- With MUL_SIGNED_EN:
  - a=0xFFFD (−3), b=5 → out=0xFFF1, ovf=0;
  - a=0x8000, b=0xFFFF → ovf=1;
  - a=0x8000, b=1 → out=0x8000, ovf=0.
